// File: rtl/sync_ram_arbiter_pkg.sv
// Shared types and default widths for the two-requester RAM port arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;

endpackage

// File: rtl/sync_ram_arbiter_winner.sv
// Winner selection for two requesters: last-owner priority from IDLE,
// owner stickiness with burst-limit preemption while owning.
module arb_winner2
  import sram_arb_pkg::*;
(
  input  arb_state_e state,
  input  logic       at_limit,
  input  logic       last_owner,
  input  logic       req0,
  input  logic       req1,
  output logic       win,
  output logic       win_valid
);

  always_comb begin
    win       = 1'b0;
    win_valid = 1'b0;
    unique case (state)
      OWN0: begin
        if (req0 && !(at_limit && req1)) begin
          win       = 1'b0;
          win_valid = 1'b1;
        end else if (req1) begin
          win       = 1'b1;
          win_valid = 1'b1;
        end
      end
      OWN1: begin
        if (req1 && !(at_limit && req0)) begin
          win       = 1'b1;
          win_valid = 1'b1;
        end else if (req0) begin
          win       = 1'b0;
          win_valid = 1'b1;
        end
      end
      default: begin
        // contention goes to whoever did not own last
        if (req0 && req1) begin
          win       = ~last_owner;
          win_valid = 1'b1;
        end else if (req0 || req1) begin
          win       = req1;
          win_valid = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/sync_ram_arbiter.sv
// Two-requester arbiter onto one single-port synchronous RAM with bounded bursts.
//   state | meaning
//   IDLE  | no access issued last cycle
//   OWN0  | r0 was granted last cycle
//   OWN1  | r1 was granted last cycle
module sync_ram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int AW        = AW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r1_req,
  input  logic          r0_we,
  input  logic          r1_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r0_din,
  input  logic [DW-1:0] r1_din,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic [DW-1:0] r1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  arb_state_e state, state_nxt;
  logic       last_owner;
  logic [3:0] burst_cnt, burst_cnt_nxt;
  logic       at_limit;
  logic       win, win_valid, win_ok, same_owner;

  assign at_limit = (burst_cnt == 4'(MAX_BURST));

  arb_winner2 u_winner (
    .state      (state),
    .at_limit   (at_limit),
    .last_owner (last_owner),
    .req0       (r0_req),
    .req1       (r1_req),
    .win        (win),
    .win_valid  (win_valid)
  );

  // Nothing leaves the block while reset is held.
  assign win_ok = win_valid & ~rst;

  always_comb begin
    r0_gnt   = 1'b0;
    r1_gnt   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (win_ok) begin
      r0_gnt   = ~win;
      r1_gnt   = win;
      ram_we   = win ? r1_we   : r0_we;
      ram_addr = win ? r1_addr : r0_addr;
      ram_din  = win ? r1_din  : r0_din;
    end
  end

  always_comb begin
    state_nxt     = IDLE;
    burst_cnt_nxt = 4'd0;
    same_owner    = 1'b0;
    if (win_valid) begin
      state_nxt  = win ? OWN1 : OWN0;
      same_owner = (state == OWN0 && !win) || (state == OWN1 && win);
      if (!same_owner)
        burst_cnt_nxt = 4'd1;
      else if (at_limit)
        burst_cnt_nxt = burst_cnt;
      else
        burst_cnt_nxt = burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= 4'd0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
      if (win_valid)
        last_owner <= win;
      r0_rvalid <= r0_gnt & ~r0_we;
      r1_rvalid <= r1_gnt & ~r1_we;
    end
  end

  assign r0_rdata = r0_rvalid ? ram_dout : '0;
  assign r1_rdata = r1_rvalid ? ram_dout : '0;

endmodule

// File: doc/sync_ram_arbiter.md
SYNC_RAM_ARBITER -- requirements
Module: sync_ram_arbiter

Interface
REQ-001 Parameter DW, default 8, data width of the shared RAM port.
REQ-002 Parameter AW, default 2, address width of the shared RAM port.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive grants to one owner while the other requester waits; legal range 1..15.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 The ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- r0_req, r1_req  in  1  access request; held until the matching gnt.
- r0_we, r1_we  in  1  1 = write, 0 = read; held with req.
- r0_addr, r1_addr  in  AW  access address.
- r0_din, r1_din  in  DW  write data.
- r0_gnt, r1_gnt  out  1  combinational; access issued this cycle.
- r0_rvalid, r1_rvalid  out  1  registered; read data present this cycle.
- r0_rdata, r1_rdata  out  DW  read data; 0 when the matching rvalid is 0.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM registered read data, valid one cycle after a read is issued.

Function
REQ-006 The block SHALL issue at most one RAM access per cycle; at most one gnt SHALL be high in any cycle.
REQ-007 The FSM SHALL have three states: IDLE, OWN0 and OWN1, plus a last-owner bit and a burst counter burst_cnt (4 bits).
REQ-008 In IDLE, the winner SHALL be:
- the sole requester, when only one requests;
- when both request, the requester that is not the last owner.
REQ-009 In OWNx, owner x SHALL keep winning while it requests, unless burst_cnt equals MAX_BURST and the other requester requests.
- When owner x loses or drops req, the other requester SHALL win if it requests.
- Otherwise there SHALL be no winner.
REQ-010 The next state SHALL be OWN<winner>, or IDLE when there is no winner; the last-owner bit SHALL update to the winner whenever a winner exists.
REQ-011 burst_cnt SHALL load 1 on a change of owner and increment on a repeat grant to the same owner, saturating at MAX_BURST; it SHALL clear to 0 in IDLE.
REQ-012 gnt of the winner, and ram_we/ram_addr/ram_din muxed from the winner's inputs, SHALL be driven in the same cycle as the winning request.
REQ-013 When there is no winner, ram_we, ram_addr and ram_din SHALL all be 0.
REQ-014 A granted read SHALL raise the matching rvalid exactly one cycle later, with rdata equal to ram_dout.
REQ-015 A granted write SHALL produce no rvalid.
REQ-016 Back-to-back reads SHALL yield one rvalid per cycle, with no bubbles.
REQ-017 A request dropped before its grant SHALL be discarded with no side effect.
REQ-018 Write-then-read to the same address in consecutive grants SHALL return the new data.

Reset
REQ-019 While rst is high, the block SHALL hold the following values at the next rising edge:
- state IDLE;
- last-owner = r1, so that r0 wins the first contention;
- burst_cnt = 0;
- both rvalid = 0.
REQ-020 While rst is high, all gnt and ram_* outputs SHALL be 0.
REQ-021 A read granted in the cycle rst rises SHALL NOT produce an rvalid; no pending state SHALL survive reset.

Structure
REQ-022 A shared package sram_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and the DW/AW default constants.
REQ-023 The winner-selection logic SHALL be one combinational sub-module arb_winner2, taking state, burst-limit flag, last-owner and both req, and returning the winner and a valid flag; the top SHALL hold the registers and the muxes.

Verification
REQ-024 The bench SHALL cover:
- Reset, then r0 writes 0xA5 to addr 2 alone, then r0 reads addr 2 -> r0_gnt in each request cycle; r0_rvalid=1 with r0_rdata=0xA5 one cycle after the read grant; r1 outputs stay 0.
- r0 and r1 both request from IDLE after reset -> r0 granted first; after r0 drops req, r1 granted the next cycle.
- Both hold req continuously with MAX_BURST=4 -> grant sequence r0 ×4, r1 ×4, r0 ×4; never two gnt high in one cycle.
- r1 issues reads to addr 0,1,2,3 back-to-back, with values 0x10..0x13 prewritten -> r1_rvalid high for 4 consecutive cycles, carrying 0x10, 0x11, 0x12, 0x13.
- rst asserted in the cycle of a granted r0 read -> r0_rvalid stays 0 next cycle; state IDLE; ram_we=0.
- r0 requests only once r1 is alone in OWN1 and r1 drops req in that cycle -> r0 granted that same cycle; burst_cnt=1.
